// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer and its pointer unit.
// Optional flush support is enabled in rob_ctrl with ROB_FLUSH_EN.
package rob_pkg;

  localparam int ROB_DEPTH = 4;
  localparam int ROB_AW    = 2;
  localparam int ARCH_AW   = 2;
  localparam int DATA_W    = 16;

  typedef logic [ROB_AW-1:0]  rob_tag_t;
  typedef logic [ARCH_AW-1:0] arch_reg_t;

  typedef struct packed {
    logic              busy;
    logic              done;
    arch_reg_t         dst;
    logic [DATA_W-1:0] val;
  } rob_entry_t;

  localparam rob_entry_t ROB_ENTRY_RST = '{busy: 1'b0, done: 1'b0,
                                           dst: {ARCH_AW{1'b0}}, val: {DATA_W{1'b0}}};

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit head/tail pointer pair with full/empty/count; reusable by any
// power-of-two circular queue.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int AW = ROB_AW
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clr,
  input  logic        i_inc_tail,
  input  logic        i_inc_head,
  output logic [AW:0] o_head,
  output logic [AW:0] o_tail,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  logic [AW:0] r_head;
  logic [AW:0] r_tail;

  // Pointer registers; the MSB toggles on every wrap of the index bits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_head <= {(AW+1){1'b0}};
      r_tail <= {(AW+1){1'b0}};
    end else if (i_clr) begin
      r_head <= {(AW+1){1'b0}};
      r_tail <= {(AW+1){1'b0}};
    end else begin
      if (i_inc_tail) r_tail <= r_tail + {{AW{1'b0}}, 1'b1};
      if (i_inc_head) r_head <= r_head + {{AW{1'b0}}, 1'b1};
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
  assign o_empty = (r_head == r_tail);
  assign o_count = r_tail - r_head;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer: in-order allocation with RAT write, CDB capture, in-order retire.
// Define ROB_FLUSH_EN to add i_flush / o_flush_done for mispredict recovery.
module rob_ctrl
  import rob_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_dq_valid,
  input  logic [ARCH_AW-1:0] i_dq_dst_addr,
  output logic              o_dq_ready,
  output logic              o_rat_valid,
  output logic [ROB_AW-1:0] o_rat_rob_addr,
  output logic [ARCH_AW-1:0] o_rat_dst_addr,
  input  logic              i_cdb_valid,
  input  logic [ROB_AW-1:0] i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_val,
  output logic              o_cmt_valid,
  output logic [ROB_AW-1:0] o_cmt_tag,
  output logic [ARCH_AW-1:0] o_cmt_dst_addr,
  output logic [DATA_W-1:0] o_cmt_val,
  output logic [ROB_AW:0]   o_count,
  output logic              o_empty
`ifdef ROB_FLUSH_EN
  ,
  input  logic              i_flush,
  output logic              o_flush_done
`endif
);

  rob_entry_t  r_ent [ROB_DEPTH];
  logic        r_rat_valid;
  rob_tag_t    r_rat_rob_addr;
  arch_reg_t   r_rat_dst_addr;
  logic        r_cmt_valid;
  rob_tag_t    r_cmt_tag;
  arch_reg_t   r_cmt_dst_addr;
  logic [DATA_W-1:0] r_cmt_val;

  logic [ROB_AW:0] w_head;
  logic [ROB_AW:0] w_tail;
  logic            w_full;
  logic            w_flush;
  logic            w_disp;
  logic            w_wb;
  logic            w_commit;
  rob_tag_t        w_head_idx;
  rob_tag_t        w_tail_idx;

`ifdef ROB_FLUSH_EN
  logic r_flush_done;
  assign w_flush      = i_flush;
  assign o_flush_done = r_flush_done;
`else
  assign w_flush = 1'b0;
`endif

  assign w_head_idx = w_head[ROB_AW-1:0];
  assign w_tail_idx = w_tail[ROB_AW-1:0];
  // Readiness comes from registered full only: a commit never frees a slot same-cycle.
  assign o_dq_ready = !w_full;
  assign w_disp     = i_dq_valid && !w_full && !w_flush;
  assign w_wb       = i_cdb_valid && r_ent[i_cdb_tag].busy && !w_flush;
  assign w_commit   = r_ent[w_head_idx].busy && r_ent[w_head_idx].done && !w_flush;

  rob_ptr #(.AW(ROB_AW)) u_ptr (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (w_flush),
    .i_inc_tail (w_disp),
    .i_inc_head (w_commit),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_full     (w_full),
    .o_empty    (o_empty),
    .o_count    (o_count)
  );

  // Entry storage: allocate at tail, capture CDB results, release at head.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= ROB_ENTRY_RST;
    end else if (w_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_ent[i] <= ROB_ENTRY_RST;
    end else begin
      if (w_disp) begin
        r_ent[w_tail_idx].busy <= 1'b1;
        r_ent[w_tail_idx].done <= 1'b0;
        r_ent[w_tail_idx].dst  <= i_dq_dst_addr;
      end
      if (w_wb) begin
        r_ent[i_cdb_tag].done <= 1'b1;
        r_ent[i_cdb_tag].val  <= i_cdb_val;
      end
      if (w_commit) begin
        r_ent[w_head_idx].busy <= 1'b0;
        r_ent[w_head_idx].done <= 1'b0;
      end
    end
  end

  // Registered RAT-write and commit strobes; address/value fields hold when idle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rat_valid    <= 1'b0;
      r_rat_rob_addr <= {ROB_AW{1'b0}};
      r_rat_dst_addr <= {ARCH_AW{1'b0}};
      r_cmt_valid    <= 1'b0;
      r_cmt_tag      <= {ROB_AW{1'b0}};
      r_cmt_dst_addr <= {ARCH_AW{1'b0}};
      r_cmt_val      <= {DATA_W{1'b0}};
    end else begin
      r_rat_valid <= w_disp;
      if (w_disp) begin
        r_rat_rob_addr <= w_tail_idx;
        r_rat_dst_addr <= i_dq_dst_addr;
      end
      r_cmt_valid <= w_commit;
      if (w_commit) begin
        r_cmt_tag      <= w_head_idx;
        r_cmt_dst_addr <= r_ent[w_head_idx].dst;
        r_cmt_val      <= r_ent[w_head_idx].val;
      end
    end
  end

`ifdef ROB_FLUSH_EN
  // One-cycle acknowledge so the RAT can drop every mapping.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_flush_done <= 1'b0;
    else         r_flush_done <= w_flush;
  end
`endif

  assign o_rat_valid    = r_rat_valid;
  assign o_rat_rob_addr = r_rat_rob_addr;
  assign o_rat_dst_addr = r_rat_dst_addr;
  assign o_cmt_valid    = r_cmt_valid;
  assign o_cmt_tag      = r_cmt_tag;
  assign o_cmt_dst_addr = r_cmt_dst_addr;
  assign o_cmt_val      = r_cmt_val;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed self-checking bench for rob_ctrl; flush steps build with ROB_FLUSH_EN.
module tb_rob_ctrl;
  import rob_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              dq_valid = 1'b0;
  logic [ARCH_AW-1:0] dq_dst = '0;
  logic              dq_ready;
  logic              rat_valid;
  logic [ROB_AW-1:0] rat_tag;
  logic [ARCH_AW-1:0] rat_dst;
  logic              cdb_valid = 1'b0;
  logic [ROB_AW-1:0] cdb_tag = '0;
  logic [DATA_W-1:0] cdb_val = '0;
  logic              cmt_valid;
  logic [ROB_AW-1:0] cmt_tag;
  logic [ARCH_AW-1:0] cmt_dst;
  logic [DATA_W-1:0] cmt_val;
  logic [ROB_AW:0]   count;
  logic              empty;
`ifdef ROB_FLUSH_EN
  logic              flush = 1'b0;
  logic              flush_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rob_ctrl dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_dq_valid     (dq_valid),
    .i_dq_dst_addr  (dq_dst),
    .o_dq_ready     (dq_ready),
    .o_rat_valid    (rat_valid),
    .o_rat_rob_addr (rat_tag),
    .o_rat_dst_addr (rat_dst),
    .i_cdb_valid    (cdb_valid),
    .i_cdb_tag      (cdb_tag),
    .i_cdb_val      (cdb_val),
    .o_cmt_valid    (cmt_valid),
    .o_cmt_tag      (cmt_tag),
    .o_cmt_dst_addr (cmt_dst),
    .o_cmt_val      (cmt_val),
    .o_count        (count),
    .o_empty        (empty)
`ifdef ROB_FLUSH_EN
    ,
    .i_flush        (flush),
    .o_flush_done   (flush_done)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rat_chk(input string tag, input logic v, input logic [1:0] t, input logic [1:0] d);
    chk({tag, ".rat_valid"}, 32'(rat_valid), 32'(v));
    chk({tag, ".rat_tag"},   32'(rat_tag),   32'(t));
    chk({tag, ".rat_dst"},   32'(rat_dst),   32'(d));
  endtask

  task automatic cmt_chk(input string tag, input logic [1:0] t, input logic [1:0] d, input logic [15:0] v);
    chk({tag, ".cmt_valid"}, 32'(cmt_valid), 32'd1);
    chk({tag, ".cmt_tag"},   32'(cmt_tag),   32'(t));
    chk({tag, ".cmt_dst"},   32'(cmt_dst),   32'(d));
    chk({tag, ".cmt_val"},   32'(cmt_val),   32'(v));
  endtask

  initial begin
    // Power-on reset
    tick(); tick();
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.ready", 32'(dq_ready), 32'd1);
    rat_chk("rst", 1'b0, 2'd0, 2'd0);
    chk("rst.cmt_valid", 32'(cmt_valid), 32'd0);
    chk("rst.cmt_val", 32'(cmt_val), 32'd0);
    rstn = 1'b1;
    tick();

    // Dispatch r0, r0, r3
    dq_valid = 1'b1; dq_dst = 2'd0; tick();
    rat_chk("d0", 1'b1, 2'd0, 2'd0);
    chk("d0.count", 32'(count), 32'd1);
    dq_dst = 2'd0; tick();
    rat_chk("d1", 1'b1, 2'd1, 2'd0);
    dq_dst = 2'd3; tick();
    rat_chk("d2", 1'b1, 2'd2, 2'd3);
    chk("d2.count", 32'(count), 32'd3);
    dq_valid = 1'b0; tick();
    rat_chk("idle", 1'b0, 2'd2, 2'd3);

    // Writeback to non-busy tag3 is ignored
    cdb_valid = 1'b1; cdb_tag = 2'd3; cdb_val = 16'hFFFF; tick();
    // Out-of-order writebacks, in-order commit
    cdb_tag = 2'd2; cdb_val = 16'h00AA; tick();
    chk("wb2.cmt_valid", 32'(cmt_valid), 32'd0);
    cdb_tag = 2'd0; cdb_val = 16'h1234; tick();
    chk("wb0.cmt_valid", 32'(cmt_valid), 32'd0);
    cdb_valid = 1'b0; tick();
    cmt_chk("c0", 2'd0, 2'd0, 16'h1234);
    chk("c0.count", 32'(count), 32'd2);
    tick();
    chk("stall1.cmt_valid", 32'(cmt_valid), 32'd0);
    tick();
    chk("stall2.cmt_valid", 32'(cmt_valid), 32'd0);
    chk("stall2.count", 32'(count), 32'd2);
    cdb_valid = 1'b1; cdb_tag = 2'd1; cdb_val = 16'h5678; tick();
    chk("wb1.cmt_valid", 32'(cmt_valid), 32'd0);
    cdb_valid = 1'b0; tick();
    cmt_chk("c1", 2'd1, 2'd0, 16'h5678);
    tick();
    cmt_chk("c2", 2'd2, 2'd3, 16'h00AA);
    chk("c2.empty", 32'(empty), 32'd1);
    tick();
    chk("c2done.cmt_valid", 32'(cmt_valid), 32'd0);

    // Two entries in flight (tags 3 and 0); tag3's earlier bogus writeback must not retire it
    dq_valid = 1'b1; dq_dst = 2'd1; tick();
    rat_chk("d3", 1'b1, 2'd3, 2'd1);
    dq_dst = 2'd2; tick();
    rat_chk("d4", 1'b1, 2'd0, 2'd2);
    dq_valid = 1'b0; tick();
    chk("ign.cmt_valid", 32'(cmt_valid), 32'd0);
    chk("ign.count", 32'(count), 32'd2);

    // Mid-run asynchronous reset
    rstn = 1'b0; #50;
    chk("mrst.count", 32'(count), 32'd0);
    chk("mrst.empty", 32'(empty), 32'd1);
    chk("mrst.ready", 32'(dq_ready), 32'd1);
    rstn = 1'b1;
    tick();
    chk("mrst.cmt_valid", 32'(cmt_valid), 32'd0);
    tick();
    chk("mrst2.cmt_valid", 32'(cmt_valid), 32'd0);
    chk("mrst2.count", 32'(count), 32'd0);

    // Fill to full, then hold a blocked request
    dq_valid = 1'b1;
    dq_dst = 2'd1; tick();
    dq_dst = 2'd2; tick();
    dq_dst = 2'd3; tick();
    dq_dst = 2'd0; tick();
    rat_chk("f3", 1'b1, 2'd3, 2'd0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.ready", 32'(dq_ready), 32'd0);
    chk("full.empty", 32'(empty), 32'd0);
    dq_dst = 2'd2; tick();
    chk("blk.rat_valid", 32'(rat_valid), 32'd0);
    chk("blk.count", 32'(count), 32'd4);

    // Full ROB with head completing: commit first, dispatch only on the next edge
    cdb_valid = 1'b1; cdb_tag = 2'd0; cdb_val = 16'hBEEF; tick();
    chk("fwb.count", 32'(count), 32'd4);
    chk("fwb.cmt_valid", 32'(cmt_valid), 32'd0);
    cdb_valid = 1'b0; tick();
    cmt_chk("fc", 2'd0, 2'd1, 16'hBEEF);
    chk("fc.count", 32'(count), 32'd3);
    chk("fc.rat_valid", 32'(rat_valid), 32'd0);
    chk("fc.ready", 32'(dq_ready), 32'd1);
    tick();
    rat_chk("fd", 1'b1, 2'd0, 2'd2);
    chk("fd.count", 32'(count), 32'd4);
    chk("fd.cmt_valid", 32'(cmt_valid), 32'd0);
    dq_valid = 1'b0;

`ifdef ROB_FLUSH_EN
    // Flush with a coincident writeback
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 2'd1; cdb_val = 16'h1111; tick();
    chk("fl.count", 32'(count), 32'd0);
    chk("fl.empty", 32'(empty), 32'd1);
    chk("fl.done", 32'(flush_done), 32'd1);
    chk("fl.cmt_valid", 32'(cmt_valid), 32'd0);
    chk("fl.rat_valid", 32'(rat_valid), 32'd0);
    flush = 1'b0; cdb_valid = 1'b0; tick();
    chk("fl2.done", 32'(flush_done), 32'd0);
    chk("fl2.cmt_valid", 32'(cmt_valid), 32'd0);
    dq_valid = 1'b1; dq_dst = 2'd3; tick();
    rat_chk("fl3", 1'b1, 2'd0, 2'd3);
    dq_valid = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
Reorder buffer for the 4-entry OoO core. It is the initiator of the RAT write interface.
- Allocates an in-order entry for each dispatched instruction and tells the RAT which ROB tag now owns the destination register.
- Captures results from the common data bus (CDB).
- Retires entries strictly in order toward the architectural register file and RAT.

Parameters:
ROB_DEPTH, 4, number of entries (power of two)
ROB_AW, 2, log2(ROB_DEPTH), width of the ROB tag
ARCH_AW, 2, architectural register index width (r0..r3)
DATA_W, 16, result value width

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  reset, asynchronous, active-low
i_dq_valid  in  1  dispatch request from the instruction queue
i_dq_dst_addr  in  ARCH_AW  architectural destination of the dispatched instruction
o_dq_ready  out  1  entry available; high when not full
o_rat_valid  out  1  RAT write strobe; drives the RAT's i_rob_valid
o_rat_rob_addr  out  ROB_AW  allocated tag; drives the RAT's i_rob_addr
o_rat_dst_addr  out  ARCH_AW  destination; drives the RAT's i_rob_dst_addr
i_cdb_valid  in  1  result broadcast valid
i_cdb_tag  in  ROB_AW  ROB tag of the result
i_cdb_val  in  DATA_W  result value
o_cmt_valid  out  1  one-cycle commit pulse
o_cmt_tag  out  ROB_AW  tag being retired (the RAT clears the mapping if it still matches)
o_cmt_dst_addr  out  ARCH_AW  architectural register written
o_cmt_val  out  DATA_W  committed value
o_count  out  ROB_AW+1  occupied entries, 0..ROB_DEPTH
o_empty  out  1  o_count==0

Behaviour:
- Storage and pointers
  - Per entry: busy, done, dst[ARCH_AW], val[DATA_W].
  - head/tail pointers are ROB_AW+1 bits wide; the MSB is the wrap bit.
  - full = (head[AW-1:0]==tail[AW-1:0]) && (MSBs differ). empty = (head==tail).
- Reset (asynchronous, i_rstn=0)
  - All busy/done bits = 0; head = tail = 0; o_count = 0; o_empty = 1; o_dq_ready = 1.
  - o_rat_valid = 0, o_cmt_valid = 0; all address and value outputs = 0.
  - Applies mid-operation as well: every in-flight entry is discarded with no commit pulse.
- Dispatch
  - Accepted on a rising edge where i_dq_valid && o_dq_ready.
  - Entry tail: busy=1, done=0, dst=i_dq_dst_addr. Tail increments, wrapping 3->0 and toggling the MSB.
  - The RAT write is registered: for the cycle after acceptance, o_rat_valid=1, o_rat_rob_addr=old tail, o_rat_dst_addr=dst. Otherwise o_rat_valid=0 and the address outputs hold their last value.
  - When i_dq_valid=1 while full, nothing changes and no RAT write occurs.
- Writeback
  - On an edge where i_cdb_valid=1 and entry[i_cdb_tag].busy=1: done=1, val=i_cdb_val.
  - A tag of a non-busy entry is ignored.
  - A repeat writeback to an already-done entry overwrites val.
- Commit
  - At most one per cycle.
  - On an edge where entry[head].busy && done are both registered true: clear busy/done, head++.
  - For the following cycle o_cmt_valid=1, with tag/dst/val taken from that entry.
  - Minimum writeback-to-commit latency is 2 edges: done is set on edge W, commit fires on edge W+1, and the pulse is visible after W+1.
- Ordering
  - A done entry behind a not-done head waits; no out-of-order retire.
- Simultaneous events
  - Dispatch and commit on the same edge: o_count unchanged.
  - o_dq_ready comes from registered full state only, with no same-cycle commit bypass. A full ROB therefore blocks dispatch for that cycle even if the head commits.
  - Writeback and dispatch targeting the same index cannot collide, because a free entry is never busy.
- Arithmetic
  - o_count = tail - head, computed modulo 2^(ROB_AW+1).

Optional Feature:
ROB_FLUSH_EN
- Defined: adds input i_flush (1 bit), for mispredict recovery.
  - On an edge with i_flush=1: all busy/done bits clear, head=tail=0.
  - Any dispatch, writeback or commit on that same edge is suppressed. o_rat_valid and o_cmt_valid are 0 the next cycle.
  - Adds output o_flush_done, a 1-cycle pulse one cycle after the flush edge. The RAT uses it to invalidate all mappings.
- Undefined: neither port exists and flush logic is absent.

Decomposition:
- Shared package rob_pkg holds:
  - constants ROB_DEPTH, ROB_AW, ARCH_AW, DATA_W;
  - typedef rob_tag_t [ROB_AW-1:0], arch_reg_t [ARCH_AW-1:0];
  - struct rob_entry_t {busy, done, dst, val}.
- One sub-module is natural: rob_ptr, a wrap-bit pointer pair with increment, full/empty and count. The same unit can be reused by the instruction queue.

Test Plan:
- Reset mid-run with 2 entries busy, pulse i_rstn low 50ns -> o_count=0, o_empty=1, o_dq_ready=1, and no o_cmt_valid after release.
- Dispatch dst r0, r0, r3 on consecutive cycles -> o_rat_valid pulses with (tag0,r0), (tag1,r0), (tag2,r3) one cycle after each acceptance; o_count=3.
- Fill 4 entries and hold i_dq_valid=1 -> o_dq_ready=0, a 5th request yields no RAT write, tail stays at 0 with MSB set.
- Starting from the 3 entries dispatched above (tag0/r0, tag1/r0, tag2/r3): CDB tag2=0x00AA, then tag0=0x1234 -> commit tag0 (r0, 0x1234) is the first o_cmt_valid. Tag2 stays stalled until CDB tag1=0x5678 arrives. Commits then follow in order: tag1 (r0, 0x5678) on consecutive cycles before tag2 (r3, 0x00AA).
- Full ROB, head done, i_dq_valid=1 -> commit fires; the dispatch is accepted on the next edge only; o_count goes 4->3->4.
- ROB_FLUSH_EN defined: 3 busy, i_flush=1 together with i_cdb_valid -> o_count=0, no commit pulse, o_flush_done pulses once.
